// File: rtl/yuv422_stream_sequencer_pkg.sv
// Shared types for the 4:2:2 stream sequencer: FSM states and chroma phase encoding.
package yuv_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        ARMED,
        WAIT_LINE,
        LINE
    } state_t;

    localparam logic PH_CB = 1'b0;
    localparam logic PH_CR = 1'b1;

endpackage

// File: rtl/yuv422_stream_sequencer_if.sv
// Camera-side controls and converter-side qualified stream for the 4:2:2 sequencer.
interface yuv422_stream_sequencer_if #(
    parameter int COL_W = 11,
    parameter int ROW_W = 10
);
    logic             enable;
    logic             frame_valid;
    logic             line_valid;
    logic             data_valid;
    logic             err_clr;

    logic             conv_valid;
    logic             phase_cr;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             sof;
    logic             eol;
    logic             eof;
    logic             line_err;
    logic             frame_err;
    logic             busy;

    modport master (
        output enable, frame_valid, line_valid, data_valid, err_clr,
        input  conv_valid, phase_cr, col, row, sof, eol, eof, line_err, frame_err, busy
    );

    modport slave (
        input  enable, frame_valid, line_valid, data_valid, err_clr,
        output conv_valid, phase_cr, col, row, sof, eol, eof, line_err, frame_err, busy
    );
endinterface

// File: rtl/yuv422_stream_sequencer.sv
// Qualifies camera words against frame/line syncs, re-aligns Cb/Cr phase every line and
// emits coordinates, frame markers and sticky sync-error flags, all one cycle after input.
module yuv422_stream_sequencer
    import yuv_stream_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COL_W    = 11,
    parameter int ROW_W    = 10
) (
    input logic                      iCLK,
    input logic                      iRST_N,
    yuv422_stream_sequencer_if.slave bus
);
    localparam logic [COL_W-1:0] H_END  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] H_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] V_END  = ROW_W'(V_ACTIVE);
    localparam logic [ROW_W-1:0] V_LAST = ROW_W'(V_ACTIVE - 1);

    state_t           state, state_nxt;
    logic [COL_W-1:0] col_cnt, col_base, col_after;
    logic [ROW_W-1:0] row_cnt, row_after;
    logic             phase, phase_base;
    logic             col_ovf, col_ovf_after, row_ovf, row_ovf_after;
    logic             line_start, in_line, row_open, word, accept;
    logic             line_end, frame_end, frame_start;
    logic             line_err_set, frame_err_set;

    // Counters saturate, so the *_ovf flags remember that extra words/lines were seen.
    always_comb begin
        line_start    = (state == WAIT_LINE) && bus.frame_valid && bus.line_valid;
        in_line       = line_start || (state == LINE);
        row_open      = row_cnt < V_END;
        col_base      = line_start ? '0 : col_cnt;
        phase_base    = line_start ? PH_CB : phase;
        word          = in_line && bus.line_valid && bus.data_valid && row_open;
        accept        = word && (col_base < H_END);
        col_after     = col_base + COL_W'(accept);
        col_ovf_after = (col_ovf && !line_start) || (word && !accept);
        line_end      = (state == LINE) && (!bus.line_valid || !bus.frame_valid);
        frame_end     = ((state == WAIT_LINE) || (state == LINE)) && !bus.frame_valid;
        frame_start   = (state == ARMED) && bus.enable && bus.frame_valid;
        line_err_set  = line_end && row_open && ((col_after != H_END) || col_ovf_after);
        row_after     = (line_end && row_open) ? row_cnt + ROW_W'(1) : row_cnt;
        row_ovf_after = row_ovf || (line_end && !row_open);
        frame_err_set = frame_end && ((row_after != V_END) || row_ovf_after);
    end

    // WAIT_FRAME only hands over once frame_valid was seen low, so a high level in ARMED is a rise.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.enable) state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (!bus.enable) state_nxt = IDLE;
                        else if (!bus.frame_valid) state_nxt = ARMED;
            ARMED:      if (!bus.enable) state_nxt = IDLE;
                        else if (bus.frame_valid) state_nxt = WAIT_LINE;
            WAIT_LINE:  if (!bus.frame_valid) state_nxt = bus.enable ? WAIT_FRAME : IDLE;
                        else if (bus.line_valid) state_nxt = LINE;
            LINE:       if (!bus.frame_valid) state_nxt = bus.enable ? WAIT_FRAME : IDLE;
                        else if (!bus.line_valid) state_nxt = WAIT_LINE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state          <= IDLE;
            col_cnt        <= '0;
            row_cnt        <= '0;
            phase          <= PH_CB;
            col_ovf        <= 1'b0;
            row_ovf        <= 1'b0;
            bus.conv_valid <= 1'b0;
            bus.phase_cr   <= 1'b0;
            bus.col        <= '0;
            bus.row        <= '0;
            bus.sof        <= 1'b0;
            bus.eol        <= 1'b0;
            bus.eof        <= 1'b0;
            bus.line_err   <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_after;
            col_ovf <= col_ovf_after;
            phase   <= accept ? ~phase_base : phase_base;
            if (frame_start) begin
                row_cnt <= '0;
                row_ovf <= 1'b0;
            end else begin
                row_cnt <= row_after;
                row_ovf <= row_ovf_after;
            end

            bus.conv_valid <= accept;
            bus.sof        <= accept && (col_base == '0) && (row_cnt == '0);
            bus.eol        <= accept && (col_base == H_LAST);
            bus.eof        <= accept && (col_base == H_LAST) && (row_cnt == V_LAST);
            if (accept) begin
                bus.phase_cr <= phase_base;
                bus.col      <= col_base;
                bus.row      <= row_cnt;
            end

            // A new error in the clearing cycle keeps the flag set.
            bus.line_err  <= line_err_set || (bus.line_err && !bus.err_clr);
            bus.frame_err <= frame_err_set || (bus.frame_err && !bus.err_clr);
            bus.busy      <= state_nxt != IDLE;
        end
    end

endmodule

// File: tb/tb_yuv422_stream_sequencer.sv
// Directed bench for the 4:2:2 stream sequencer at H_ACTIVE=8, V_ACTIVE=4.
module tb_yuv422_stream_sequencer;

    localparam int H = 8;
    localparam int V = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    yuv422_stream_sequencer_if #(.COL_W(11), .ROW_W(10)) bus ();

    yuv422_stream_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .COL_W(11), .ROW_W(10)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic fv, lv, dv;
        logic v, ph;
        int   col, row;
        logic sof, eol, eof;
    } vec_t;

    typedef struct {
        int   col, row;
        logic ph, sof, eol, eof;
    } cap_t;

    vec_t tbl[$];
    cap_t cap[256];
    int   mon_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Every accepted word lands here, one record per oConv_valid cycle.
    always @(negedge clk) begin
        if (bus.conv_valid) begin
            cap[mon_n % 256] = '{int'(bus.col), int'(bus.row), bus.phase_cr, bus.sof, bus.eol, bus.eof};
            mon_n++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic fv, input logic lv, input logic dv);
        @(negedge clk);
        bus.frame_valid = fv;
        bus.line_valid  = lv;
        bus.data_valid  = dv;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // n cycles of line_valid, data_valid dropped on cycle 'drop', then two blanking cycles.
    task automatic line(input int n, input int drop);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, k != drop);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    task automatic chk_cap(input string nm, input int idx, input int col, input int row,
                           input int ph, input int sof, input int eol, input int eof);
        chk({nm, " col"}, cap[idx % 256].col, col);
        chk({nm, " row"}, cap[idx % 256].row, row);
        chk({nm, " phase"}, int'(cap[idx % 256].ph), ph);
        chk({nm, " sof"}, int'(cap[idx % 256].sof), sof);
        chk({nm, " eol"}, int'(cap[idx % 256].eol), eol);
        chk({nm, " eof"}, int'(cap[idx % 256].eof), eof);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, int'({bus.conv_valid, bus.phase_cr, bus.col, bus.row, bus.sof, bus.eol,
                      bus.eof, bus.line_err, bus.frame_err, bus.busy}), 0);
    endtask

    function automatic void add(input logic fv, input logic lv, input logic dv, input logic v,
                                input logic ph, input int col, input int row,
                                input logic sof, input logic eol, input logic eof);
        tbl.push_back('{fv, lv, dv, v, ph, col, row, sof, eol, eof});
    endfunction

    int base;

    initial begin
        bus.enable = 1'b0; bus.frame_valid = 1'b0; bus.line_valid = 1'b0;
        bus.data_valid = 1'b0; bus.err_clr = 1'b0;

        // Test 1 vectors: arm, then four 8-word lines with two blanking cycles, then frame end.
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++)
                add(1, 1, 1, 1, logic'(c % 2), c, r, (c == 0 && r == 0), (c == H - 1),
                    (c == H - 1 && r == V - 1));
            add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset state");
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1
        bus.enable = 1'b1;
        foreach (tbl[i]) begin
            cyc(tbl[i].fv, tbl[i].lv, tbl[i].dv);
            settle();
            chk($sformatf("t1[%0d] valid", i), int'(bus.conv_valid), int'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("t1[%0d] phase", i), int'(bus.phase_cr), int'(tbl[i].ph));
                chk($sformatf("t1[%0d] col", i), int'(bus.col), tbl[i].col);
                chk($sformatf("t1[%0d] row", i), int'(bus.row), tbl[i].row);
            end
            chk($sformatf("t1[%0d] sof", i), int'(bus.sof), int'(tbl[i].sof));
            chk($sformatf("t1[%0d] eol", i), int'(bus.eol), int'(tbl[i].eol));
            chk($sformatf("t1[%0d] eof", i), int'(bus.eof), int'(tbl[i].eof));
        end
        chk("t1 line_err", int'(bus.line_err), 0);
        chk("t1 frame_err", int'(bus.frame_err), 0);
        chk("t1 busy", int'(bus.busy), 1);

        // Test 2: frame already running when enabled
        @(negedge clk);
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.frame_valid = 1'b1;
        #1;
        chk_all_zero("t2 reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.enable = 1'b1;
        base = mon_n;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        line(H, -1);
        line(H, -1);
        settle();
        chk("t2 no words mid-frame", mon_n - base, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        base = mon_n;
        line(H, -1);
        settle();
        chk("t2 line0 count", mon_n - base, H);
        chk_cap("t2 first", base, 0, 0, 0, 1, 0, 0);

        // Test 3: word 3 of line 1 missing
        chk("t3 line_err before", int'(bus.line_err), 0);
        base = mon_n;
        line(H, 3);
        settle();
        chk("t3 line1 count", mon_n - base, H - 1);
        chk_cap("t3 after gap", base + 3, 3, 1, 1, 0, 0, 0);
        chk_cap("t3 last", base + 6, 6, 1, 0, 0, 0, 0);
        chk("t3 line_err", int'(bus.line_err), 1);
        base = mon_n;
        line(H, -1);
        settle();
        chk_cap("t3 line2 first", base, 0, 2, 0, 0, 0, 0);
        chk_cap("t3 line2 last", base + 7, 7, 2, 1, 0, 1, 0);
        clr_pulse();
        settle();
        chk("t3 line_err cleared", int'(bus.line_err), 0);

        // Test 4: 10-word line
        base = mon_n;
        line(H + 2, -1);
        settle();
        chk("t4 count", mon_n - base, H);
        chk_cap("t4 last", base + 7, 7, 3, 1, 0, 1, 1);
        chk("t4 phase held", int'(bus.phase_cr), 1);
        chk("t4 valid low", int'(bus.conv_valid), 0);
        chk("t4 line_err", int'(bus.line_err), 1);
        chk("t4 frame_err", int'(bus.frame_err), 0);

        // Test 5: fifth line in a 4-line frame
        base = mon_n;
        line(H, -1);
        cyc(0, 0, 0);
        settle();
        chk("t5 extra line dropped", mon_n - base, 0);
        chk("t5 frame_err", int'(bus.frame_err), 1);
        clr_pulse();
        settle();
        chk("t5 line_err cleared", int'(bus.line_err), 0);
        chk("t5 frame_err cleared", int'(bus.frame_err), 0);

        // Test 6: reset mid-line, then resync and disable mid-frame
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        base = mon_n;
        for (int k = 0; k < 4; k++) cyc(1, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 words before reset", mon_n - base, 3);
        chk_all_zero("t6 reset outputs");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = mon_n;
        line(H - 4, -1);
        line(H, -1);
        line(H, -1);
        settle();
        chk("t6 no words until new frame", mon_n - base, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        base = mon_n;
        line(H, -1);
        line(H, -1);
        bus.enable = 1'b0;
        settle();
        chk("t6 busy after disable", int'(bus.busy), 1);
        line(H, -1);
        line(H, -1);
        cyc(0, 0, 0);
        settle();
        chk("t6 frame count", mon_n - base, H * V);
        chk_cap("t6 first", base, 0, 0, 0, 1, 0, 0);
        chk_cap("t6 last", base + H * V - 1, 7, 3, 1, 0, 1, 1);
        chk("t6 busy idle", int'(bus.busy), 0);
        chk("t6 errors", int'({bus.line_err, bus.frame_err}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
